// File: rtl/sopc_led_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sopc_led_pkg : shared mode encodings, register map and reset values
// Rev 1.0
// -----------------------------------------------------------------------------
package sopc_led_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_PWM    = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_CHASE  = 2'b11
    } led_mode_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DUTY   = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // Enabled, direct mode: the PIO pattern reaches the pins straight out of reset.
    localparam logic [2:0] CTRL_RESET = 3'b001;
    localparam logic [7:0] DUTY_RESET = 8'hFF;

endpackage : sopc_led_pkg
`default_nettype wire

// File: rtl/sopc_led_tick_gen.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sopc_led_tick_gen : PERIOD prescaler, one-cycle tick every PERIOD+1 cycles
// Rev 1.0
// -----------------------------------------------------------------------------
module sopc_led_tick_gen #(
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    tick
);

    logic [PERIOD_WIDTH-1:0] presc_cnt_q;
    logic [PERIOD_WIDTH-1:0] presc_cnt_d;
    logic                    at_period;

    assign at_period = (presc_cnt_q == period);

    // A clear always wins over a tick falling due in the same cycle.
    assign tick = enable & ~clear & at_period;

    always_comb begin
        presc_cnt_d = presc_cnt_q + PERIOD_WIDTH'(1);
        if (!enable || clear || at_period) begin
            presc_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end

endmodule : sopc_led_tick_gen
`default_nettype wire

// File: rtl/sopc_base_led_driver.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sopc_base_led_driver : LED output stage (direct/PWM/blink/chase) with Avalon-MM slave
// Rev 1.0
// -----------------------------------------------------------------------------
module sopc_base_led_driver #(
    parameter int                       LED_WIDTH    = 8,
    parameter int                       PERIOD_WIDTH = 24,
    parameter logic [PERIOD_WIDTH-1:0]  PERIOD_RESET = 24'd4999999
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    input  logic [LED_WIDTH-1:0] led_pattern,
    output logic [LED_WIDTH-1:0] leds
);

    import sopc_led_pkg::*;

    localparam int POS_W = $clog2(LED_WIDTH);

    logic [2:0]              ctrl_q,    ctrl_d;
    logic [7:0]              duty_q,    duty_d;
    logic [PERIOD_WIDTH-1:0] period_q,  period_d;
    logic [LED_WIDTH-1:0]    pattern_q;
    logic [LED_WIDTH-1:0]    leds_q,    leds_d;
    logic [7:0]              pwm_cnt_q, pwm_cnt_d;
    logic                    phase_q,   phase_d;
    logic [POS_W-1:0]        pos_q,     pos_d;

    logic                    wr, wr_ctrl, wr_duty, wr_period;
    logic                    enable, tick, pwm_on;
    led_mode_e               mode;
    logic [2*LED_WIDTH-1:0]  rot_wide;
    logic [LED_WIDTH-1:0]    rotated;
    logic                    unused_wdata;

    assign wr        = chipselect & ~write_n;
    assign wr_ctrl   = wr & (address == ADDR_CTRL);
    assign wr_duty   = wr & (address == ADDR_DUTY);
    assign wr_period = wr & (address == ADDR_PERIOD);

    assign enable = ctrl_q[0];
    assign mode   = led_mode_e'(ctrl_q[2:1]);

    assign unused_wdata = ^writedata[31:PERIOD_WIDTH];

    sopc_led_tick_gen #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .clear   (wr_ctrl | wr_period),
        .period  (period_q),
        .tick    (tick)
    );

    // Rotate left by pos: the upper half of the doubled pattern shifted left.
    assign rot_wide = {pattern_q, pattern_q} << pos_q;
    assign rotated  = rot_wide[2*LED_WIDTH-1:LED_WIDTH];

    assign pwm_on = (duty_q == 8'hFF) | (pwm_cnt_q < duty_q);

    always_comb begin
        ctrl_d    = ctrl_q;
        duty_d    = duty_q;
        period_d  = period_q;
        pwm_cnt_d = enable ? (pwm_cnt_q + 8'd1) : 8'd0;
        phase_d   = phase_q;
        pos_d     = pos_q;
        leds_d    = '0;

        if (wr_ctrl)   ctrl_d   = writedata[2:0];
        if (wr_duty)   duty_d   = writedata[7:0];
        if (wr_period) period_d = writedata[PERIOD_WIDTH-1:0];

        if (!enable || wr_ctrl) begin
            phase_d = 1'b0;
            pos_d   = '0;
        end else if (tick) begin
            phase_d = ~phase_q;
            pos_d   = (pos_q == POS_W'(LED_WIDTH - 1)) ? '0 : pos_q + POS_W'(1);
        end

        if (enable) begin
            case (mode)
                MODE_DIRECT: leds_d = pattern_q;
                MODE_PWM:    leds_d = pwm_on  ? pattern_q : '0;
                MODE_BLINK:  leds_d = phase_q ? pattern_q : '0;
                MODE_CHASE:  leds_d = rotated;
                default:     leds_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_q    <= CTRL_RESET;
            duty_q    <= DUTY_RESET;
            period_q  <= PERIOD_RESET;
            pattern_q <= '0;
            leds_q    <= '0;
            pwm_cnt_q <= '0;
            phase_q   <= 1'b0;
            pos_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            duty_q    <= duty_d;
            period_q  <= period_d;
            pattern_q <= led_pattern;
            leds_q    <= leds_d;
            pwm_cnt_q <= pwm_cnt_d;
            phase_q   <= phase_d;
            pos_q     <= pos_d;
        end
    end

    assign leds = leds_q;

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:   readdata[2:0]              = ctrl_q;
            ADDR_DUTY:   readdata[7:0]              = duty_q;
            ADDR_PERIOD: readdata[PERIOD_WIDTH-1:0] = period_q;
            ADDR_STATUS: begin
                readdata[0]              = phase_q;
                readdata[1 +: POS_W]     = pos_q;
                readdata[8 +: LED_WIDTH] = leds_q;
            end
            default:     readdata = '0;
        endcase
    end

endmodule : sopc_base_led_driver
`default_nettype wire

// File: tb/tb_sopc_base_led_driver.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_sopc_base_led_driver : register table, directed mode sequences, random run vs model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_sopc_base_led_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  led_pattern;
    logic [7:0]  leds;

    int n_pass  = 0;
    int n_total = 0;

    sopc_base_led_driver dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .led_pattern (led_pattern),
        .leds        (leds)
    );

    always #5 clk = ~clk;

    // Reference model: registers plus event timestamps; tick count and PWM
    // counter are derived arithmetically from elapsed cycles.
    longint      cyc = 0;
    bit          m_valid = 0;
    logic [2:0]  m_ctrl;
    logic [7:0]  m_duty;
    logic [23:0] m_period;
    logic [7:0]  m_patq;
    logic [7:0]  m_leds;
    longint      m_clr;
    longint      m_base;
    longint      m_en;

    function automatic longint ticks_now();
        if (!m_ctrl[0]) return 0;
        return m_base + (cyc - m_clr) / (longint'(m_period) + 1);
    endfunction

    function automatic int pwm_now();
        if (!m_ctrl[0]) return 0;
        return int'((cyc - m_en) % 256);
    endfunction

    function automatic logic [7:0] rotl_model(input logic [7:0] p, input int s);
        logic [7:0] o;
        for (int i = 0; i < 8; i++) o[(i + s) % 8] = p[i];
        return o;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        longint t = ticks_now();
        case (a)
            2'd0:    return {29'd0, m_ctrl};
            2'd1:    return {24'd0, m_duty};
            2'd2:    return {8'd0, m_period};
            default: return {16'd0, m_leds, 4'd0, 3'(t % 8), 1'(t % 2)};
        endcase
    endfunction

    task automatic model_update();
        longint     t  = ticks_now();
        int         pw = pwm_now();
        logic [7:0] nl = 8'h00;
        bit         wr = chipselect && !write_n;
        if (!reset_n) begin
            m_ctrl = 3'b001; m_duty = 8'hFF; m_period = 24'd4999999;
            m_patq = 8'h00; m_leds = 8'h00;
            m_clr = cyc + 1; m_base = 0; m_en = cyc + 1;
            m_valid = 1;
        end else begin
            if (m_ctrl[0]) begin
                case (m_ctrl[2:1])
                    2'd0: nl = m_patq;
                    2'd1: nl = (m_duty == 8'hFF || pw < int'(m_duty)) ? m_patq : 8'h00;
                    2'd2: nl = (t % 2 == 1) ? m_patq : 8'h00;
                    default: nl = rotl_model(m_patq, int'(t % 8));
                endcase
            end
            m_leds = nl;
            m_patq = led_pattern;
            if (wr && address == 2'd0) begin
                if (!m_ctrl[0] && writedata[0]) m_en = cyc + 1;
                m_ctrl = writedata[2:0];
                m_clr = cyc + 1; m_base = 0;
            end
            if (wr && address == 2'd1) m_duty = writedata[7:0];
            if (wr && address == 2'd2) begin
                m_base = t; m_clr = cyc + 1;
                m_period = writedata[23:0];
            end
        end
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic step();
        @(negedge clk);
        if (m_valid) begin
            check("model_leds", {24'd0, leds}, {24'd0, m_leds});
            check("model_readdata", readdata, exp_rd(address));
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(name, readdata, exp);
    endtask

    typedef struct {
        logic        cs;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  rd_addr;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t   vecs[8];
    logic [7:0] blink_exp[12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h0F,
                                  8'h0F, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] chase_exp[9]  = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18,
                                  8'h30, 8'h60, 8'hC0, 8'h81};

    initial begin
        int on_cnt;
        vecs[0] = '{1'b1, 2'd0, 32'hFFFF_FFF8, 2'd0, 32'h0000_0000};
        vecs[1] = '{1'b1, 2'd1, 32'hABCD_EF40, 2'd1, 32'h0000_0040};
        vecs[2] = '{1'b0, 2'd1, 32'h0000_0011, 2'd1, 32'h0000_0040};
        vecs[3] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'h00FF_FFFF};
        vecs[4] = '{1'b1, 2'd2, 32'h0000_0003, 2'd2, 32'h0000_0003};
        vecs[5] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000};
        vecs[6] = '{1'b1, 2'd0, 32'hFFFF_FFFE, 2'd0, 32'h0000_0006};
        vecs[7] = '{1'b1, 2'd0, 32'h0000_0001, 2'd0, 32'h0000_0001};

        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = '0; led_pattern = 8'hA5;

        // Reset and release
        @(posedge clk); #1;
        steps(3);
        check("reset_leds", {24'd0, leds}, 32'h0);
        rd_chk("reset_ctrl", 2'd0, 32'h1);
        reset_n = 1'b1;
        step();
        check("release_leds_1", {24'd0, leds}, 32'h0);
        step();
        check("release_leds_2", {24'd0, leds}, 32'hA5);

        // PWM duty windows
        led_pattern = 8'hFF;
        do_write(2'd1, 32'h40);
        do_write(2'd0, 32'h3);
        steps(2);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin step(); if (leds == 8'hFF) on_cnt++; end
        check("pwm_duty40_on", 32'(on_cnt), 32'd64);
        do_write(2'd1, 32'h00);
        steps(2);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin step(); if (leds != 8'h00) on_cnt++; end
        check("pwm_duty00_on", 32'(on_cnt), 32'd0);
        do_write(2'd1, 32'hFF);
        steps(2);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin step(); if (leds == 8'hFF) on_cnt++; end
        check("pwm_dutyFF_on", 32'(on_cnt), 32'd256);

        // Blink, PERIOD=3
        led_pattern = 8'h0F;
        do_write(2'd2, 32'h3);
        steps(2);
        do_write(2'd0, 32'h5);
        for (int k = 0; k < 12; k++) begin
            step();
            check($sformatf("blink_leds_%0d", k), {24'd0, leds}, {24'd0, blink_exp[k]});
        end

        // CTRL write landing on a due tick
        do_write(2'd0, 32'h5);
        steps(3);
        do_write(2'd0, 32'h5);
        rd_chk("tickdrop_phase_w5", 2'd3, {16'd0, leds, 8'd0} & 32'h0000FF00);
        steps(3);
        rd_chk("tickdrop_phase_w8", 2'd3, {16'd0, leds, 8'd0} & 32'h0000FF00);
        step();
        address = 2'd3; #1;
        check("tickdrop_phase_w9", {31'd0, readdata[0]}, 32'd1);

        // Chase, PERIOD=0
        led_pattern = 8'h81;
        do_write(2'd2, 32'h0);
        steps(2);
        do_write(2'd0, 32'h7);
        for (int k = 0; k < 9; k++) begin
            step();
            check($sformatf("chase_leds_%0d", k), {24'd0, leds}, {24'd0, chase_exp[k]});
        end

        // Disable then re-enable chase
        do_write(2'd0, 32'h0);
        step();
        check("disable_leds", {24'd0, leds}, 32'h0);
        do_write(2'd0, 32'h7);
        step();
        check("reenable_leds_0", {24'd0, leds}, 32'h81);
        step();
        check("reenable_leds_1", {24'd0, leds}, 32'h03);

        // One-cycle reset while a CTRL write is on the bus
        reset_n = 1'b0;
        do_write(2'd0, 32'h6);
        reset_n = 1'b1;
        check("midreset_leds", {24'd0, leds}, 32'h0);
        rd_chk("midreset_ctrl", 2'd0, 32'h1);
        rd_chk("midreset_duty", 2'd1, 32'hFF);

        // Register table
        for (int i = 0; i < 8; i++) begin
            chipselect = vecs[i].cs; write_n = 1'b0;
            address = vecs[i].addr; writedata = vecs[i].wdata;
            step();
            chipselect = 1'b0; write_n = 1'b1;
            address = vecs[i].rd_addr;
            step();
            check($sformatf("regvec_%0d", i), readdata, vecs[i].exp);
        end

        // Randomized run against the model
        do_write(2'd2, 32'h2);
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] a;
            logic [31:0] d;
            a = 2'($urandom_range(0, 3));
            led_pattern = 8'($urandom);
            address = a;
            reset_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 7) == 0) begin
                case (a)
                    2'd0: d = {29'd0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0)};
                    2'd1: d = ($urandom_range(0, 2) == 0) ? 32'h0 :
                              ($urandom_range(0, 1) == 0) ? 32'hFF : $urandom;
                    2'd2: d = 32'($urandom_range(0, 5));
                    default: d = $urandom;
                endcase
                chipselect = 1'b1;
                write_n = ($urandom_range(0, 3) == 0);
                writedata = d;
            end else begin
                chipselect = ($urandom_range(0, 1) == 0);
                write_n = 1'b1;
            end
            step();
            chipselect = 1'b0; write_n = 1'b1; reset_n = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sopc_base_led_driver
`default_nettype wire
